i2c_byte_sequencer: RTL

I2C_BYTE_SEQUENCER -- requirements
Module: i2c_byte_sequencer

---
 rtl/i2c_byte_sequencer_if.sv | 39 +++
 rtl/i2c_byte_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_sequencer_if.sv
// Host-side and I2C-master-side signals of the byte sequencer.
// The sequencer connects through the slave modport; its environment uses the master modport.
interface i2c_byte_sequencer_if;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       rx_rd;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       start;
  logic       rw;
  logic [6:0] slave_addr;
  logic [3:0] len;
  logic       active;
  logic       done;
  logic       reject;
  logic       ack_err;
  logic       m_enable;
  logic       m_rw;
  logic [6:0] m_addr;
  logic [7:0] m_data_wr;
  logic       m_busy;
  logic       m_ack_error;
  logic [7:0] m_data_rd;

  modport slave (
    input  tx_wr, tx_data, rx_rd, start, rw, slave_addr, len,
           m_busy, m_ack_error, m_data_rd,
    output tx_full, rx_data, rx_empty, active, done, reject, ack_err,
           m_enable, m_rw, m_addr, m_data_wr
  );

  modport master (
    output tx_wr, tx_data, rx_rd, start, rw, slave_addr, len,
           m_busy, m_ack_error, m_data_rd,
    input  tx_full, rx_data, rx_empty, active, done, reject, ack_err,
           m_enable, m_rw, m_addr, m_data_wr
  );
endinterface

// File: rtl/i2c_byte_sequencer.sv
// Feeds a byte-level I2C master from a TX FIFO and collects read bytes into an RX FIFO,
// pacing each byte on the master's busy edges.
module i2c_byte_sequencer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  i2c_byte_sequencer_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam int TX = 0;
  localparam int RX = 1;

  typedef enum logic [2:0] {IDLE, ISSUE, XFER, STOP_WAIT, FINISH} state_t;

  state_t        state_reg, state_next;
  logic          busy_q_reg;
  logic          rw_reg, rw_next;
  logic [6:0]    addr_reg, addr_next;
  logic [CW-1:0] remain_reg, remain_next;
  logic          m_enable_reg, m_enable_next;
  logic [7:0]    m_data_wr_reg, m_data_wr_next;
  logic          ack_err_reg, ack_err_next;
  logic          reject_reg, reject_next;
  logic [7:0]    rx_last_reg;

  logic                 busy_rise, busy_fall, start_ok, tx_pop, rx_push, rx_empty;
  logic [CW-1:0]        n_req;
  logic [1:0]           fifo_push_req, fifo_pop_req;
  logic [1:0][7:0]      fifo_wdata, fifo_head;
  logic [1:0][CW-1:0]   fifo_count;

  assign fifo_push_req = {rx_push, bus.tx_wr};
  assign fifo_pop_req  = {bus.rx_rd, tx_pop};
  assign fifo_wdata    = {bus.m_data_rd, bus.tx_data};

  // Both FIFOs share one structure; a push into a full FIFO only lands when a pop frees a slot.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push_ok, pop_ok;

    assign pop_ok  = fifo_pop_req[gi] && (count_reg != '0);
    assign push_ok = fifo_push_req[gi] && ((count_reg != DEPTH_C) || pop_ok);

    always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= fifo_wdata[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        if (push_ok && !pop_ok)      count_reg <= count_reg + CW'(1);
        else if (pop_ok && !push_ok) count_reg <= count_reg - CW'(1);
      end
    end

    assign fifo_head[gi]  = mem[rd_ptr_reg];
    assign fifo_count[gi] = count_reg;
  end

  assign busy_rise = bus.m_busy && !busy_q_reg;
  assign busy_fall = !bus.m_busy && busy_q_reg;
  assign n_req     = (bus.len == 4'd0) ? DEPTH_C : CW'(bus.len);
  assign start_ok  = bus.rw ? ((DEPTH_C - fifo_count[RX]) >= n_req)
                            : (fifo_count[TX] >= n_req);

  always_comb begin
    state_next     = state_reg;
    rw_next        = rw_reg;
    addr_next      = addr_reg;
    remain_next    = remain_reg;
    m_enable_next  = m_enable_reg;
    m_data_wr_next = m_data_wr_reg;
    ack_err_next   = ack_err_reg;
    reject_next    = 1'b0;
    tx_pop         = 1'b0;
    rx_push        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (start_ok) begin
            rw_next       = bus.rw;
            addr_next     = bus.slave_addr;
            remain_next   = n_req;
            ack_err_next  = 1'b0;
            m_enable_next = 1'b1;
            state_next    = ISSUE;
            if (!bus.rw) begin
              tx_pop         = 1'b1;
              m_data_wr_next = fifo_head[TX];
            end
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      ISSUE: state_next = XFER;
      XFER: begin
        // The master latches the current byte on its busy rise, so the next one is staged then.
        if (busy_rise) begin
          remain_next = remain_reg - CW'(1);
          if (remain_reg == CW'(1)) begin
            m_enable_next = 1'b0;
            state_next    = STOP_WAIT;
          end else if (!rw_reg) begin
            tx_pop         = 1'b1;
            m_data_wr_next = fifo_head[TX];
          end
        end
        if (busy_fall) begin
          rx_push = rw_reg;
          if (bus.m_ack_error) begin
            ack_err_next  = 1'b1;
            m_enable_next = 1'b0;
            state_next    = STOP_WAIT;
          end
        end
      end
      STOP_WAIT: begin
        if (busy_fall) begin
          rx_push = rw_reg;
          if (bus.m_ack_error) begin
            ack_err_next  = 1'b1;
            m_enable_next = 1'b0;
          end
        end else if (!bus.m_busy) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      busy_q_reg    <= 1'b0;
      rw_reg        <= 1'b0;
      addr_reg      <= '0;
      remain_reg    <= '0;
      m_enable_reg  <= 1'b0;
      m_data_wr_reg <= '0;
      ack_err_reg   <= 1'b0;
      reject_reg    <= 1'b0;
      rx_last_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      busy_q_reg    <= bus.m_busy;
      rw_reg        <= rw_next;
      addr_reg      <= addr_next;
      remain_reg    <= remain_next;
      m_enable_reg  <= m_enable_next;
      m_data_wr_reg <= m_data_wr_next;
      ack_err_reg   <= ack_err_next;
      reject_reg    <= reject_next;
      if (bus.rx_rd && !rx_empty) rx_last_reg <= fifo_head[RX];
    end
  end

  // Once the RX FIFO drains, rx_data keeps showing the last byte handed out.
  assign rx_empty      = (fifo_count[RX] == '0);
  assign bus.rx_empty  = rx_empty;
  assign bus.rx_data   = rx_empty ? rx_last_reg : fifo_head[RX];
  assign bus.tx_full   = (fifo_count[TX] == DEPTH_C);
  assign bus.active    = (state_reg == ISSUE) || (state_reg == XFER) || (state_reg == STOP_WAIT);
  assign bus.done      = (state_reg == FINISH);
  assign bus.reject    = reject_reg;
  assign bus.ack_err   = ack_err_reg;
  assign bus.m_enable  = m_enable_reg;
  assign bus.m_rw      = rw_reg;
  assign bus.m_addr    = addr_reg;
  assign bus.m_data_wr = m_data_wr_reg;
endmodule
